// File: rtl/id_hazard_scoreboard_pkg.sv
// id_hazard_scoreboard_pkg: shared pipeline register-index width, slot type and source-match helper
package id_hazard_scoreboard_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic             reg_write;
    logic [REG_W-1:0] rd;
    logic             mem_read;
  } slot_t;
  function automatic logic slot_match(slot_t s, logic use_rs, logic use_rt, logic [REG_W-1:0] rs, logic [REG_W-1:0] rt);
    return s.reg_write & ((use_rs & (s.rd == rs)) | (use_rt & (s.rd == rt)));
  endfunction
endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// id_hazard_if: ID-stage instruction fields in, EX/MEM slot and stall status out
interface id_hazard_if #(parameter int CNT_W = 32);
  import id_hazard_scoreboard_pkg::*;
  logic             id_Valid;
  logic             id_RegWrite;
  logic [REG_W-1:0] id_RegisterRd;
  logic             id_MemRead;
  logic             id_UseRs;
  logic             id_UseRt;
  logic [REG_W-1:0] RFR1;
  logic [REG_W-1:0] RFR2;
  logic             id_MulDiv;
  logic             id_UseHiLo;
  logic             IDFlush;
  logic             Stall;
  logic             exe_RegWrite;
  logic [REG_W-1:0] exe_RegisterRd;
  logic             exe_MemRead;
  logic             mem_RegWrite;
  logic [REG_W-1:0] mem_RegisterRd;
  logic             mem_MemRead;
  logic             MDUBusy;
  logic [CNT_W-1:0] StallCount;
  modport master (
    output id_Valid, id_RegWrite, id_RegisterRd, id_MemRead, id_UseRs, id_UseRt, RFR1, RFR2, id_MulDiv, id_UseHiLo, IDFlush,
    input  Stall, exe_RegWrite, exe_RegisterRd, exe_MemRead, mem_RegWrite, mem_RegisterRd, mem_MemRead, MDUBusy, StallCount
  );
  modport slave (
    input  id_Valid, id_RegWrite, id_RegisterRd, id_MemRead, id_UseRs, id_UseRt, RFR1, RFR2, id_MulDiv, id_UseHiLo, IDFlush,
    output Stall, exe_RegWrite, exe_RegisterRd, exe_MemRead, mem_RegWrite, mem_RegisterRd, mem_MemRead, MDUBusy, StallCount
  );
endinterface

// File: rtl/id_hazard_scoreboard_mdu_busy_counter.sv
// mdu_busy_counter: reloads on an accepted mul/div, counts down, busy while nonzero
module mdu_busy_counter #(parameter int MDU_LAT = 4) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);
  logic [3:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load ? 4'(MDU_LAT) : (cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q);
    busy  = cnt_q != 4'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: tracks EX/MEM destinations and stalls ID on load-use or busy-MDU hazards
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input logic        clk,
  input logic        rst,
  id_hazard_if.slave bus
);
  slot_t            ex_q, ex_d, mem_q, mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use, mdu_haz, stall, accept, mdu_busy;
  always_comb begin
    load_use = (ex_q.mem_read & slot_match(ex_q, bus.id_UseRs, bus.id_UseRt, bus.RFR1, bus.RFR2))
             | (mem_q.mem_read & slot_match(mem_q, bus.id_UseRs, bus.id_UseRt, bus.RFR1, bus.RFR2));
    mdu_haz  = mdu_busy & (bus.id_UseHiLo | bus.id_MulDiv);
    stall    = bus.id_Valid & ~bus.IDFlush & (load_use | mdu_haz);
    accept   = bus.id_Valid & ~bus.IDFlush & ~stall;
    ex_d     = accept ? slot_t'{reg_write: bus.id_RegWrite & (bus.id_RegisterRd != REG_ZERO),
                                rd: bus.id_RegisterRd, mem_read: bus.id_MemRead} : slot_t'('0);
    mem_d    = ex_q;
    cnt_d    = (stall && ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  mdu_busy_counter #(.MDU_LAT(MDU_LAT)) u_mdu (
    .clk  (clk),
    .rst  (rst),
    .load (accept & bus.id_MulDiv),
    .busy (mdu_busy)
  );
  assign bus.Stall          = stall;
  assign bus.exe_RegWrite   = ex_q.reg_write;
  assign bus.exe_RegisterRd = ex_q.rd;
  assign bus.exe_MemRead    = ex_q.mem_read;
  assign bus.mem_RegWrite   = mem_q.reg_write;
  assign bus.mem_RegisterRd = mem_q.rd;
  assign bus.mem_MemRead    = mem_q.mem_read;
  assign bus.MDUBusy        = mdu_busy;
  assign bus.StallCount     = cnt_q;
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb_id_hazard_scoreboard: scoreboarded EX/MEM slot checks plus inline stall/MDU/counter checks
module tb_id_hazard_scoreboard;
  localparam int CW = 2;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
  logic [6:0] exp_q[$];
  logic [6:0] prev_exe = '0;
  id_hazard_if #(.CNT_W(CW)) bus();
  id_hazard_scoreboard #(.MDU_LAT(4), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic set_in(input logic v, rw, input logic [4:0] rd, input logic mr, urs, urt,
                        input logic [4:0] r1, r2, input logic md, hl, fl);
    bus.id_Valid = v; bus.id_RegWrite = rw; bus.id_RegisterRd = rd; bus.id_MemRead = mr;
    bus.id_UseRs = urs; bus.id_UseRt = urt; bus.RFR1 = r1; bus.RFR2 = r2;
    bus.id_MulDiv = md; bus.id_UseHiLo = hl; bus.IDFlush = fl;
  endtask
  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic tick(input logic [6:0] e);
    logic [6:0] exp_exe;
    exp_q.push_back(e);
    @(posedge clk); #1;
    exp_exe = exp_q.pop_front();
    checks++;
    if ({bus.exe_RegWrite, bus.exe_RegisterRd, bus.exe_MemRead} !== exp_exe) begin
      failures++;
      $display("FAIL exe_slot t=%0t got=%b exp=%b", $time, {bus.exe_RegWrite, bus.exe_RegisterRd, bus.exe_MemRead}, exp_exe);
    end
    checks++;
    if ({bus.mem_RegWrite, bus.mem_RegisterRd, bus.mem_MemRead} !== prev_exe) begin
      failures++;
      $display("FAIL mem_slot t=%0t got=%b exp=%b", $time, {bus.mem_RegWrite, bus.mem_RegisterRd, bus.mem_MemRead}, prev_exe);
    end
    prev_exe = exp_exe;
  endtask
  task automatic exp_stall(input logic s, input string nm);
    #1; checks++;
    if (bus.Stall !== s) begin failures++; $display("FAIL stall_%s got=%b exp=%b", nm, bus.Stall, s); end
  endtask
  task automatic exp_cnt(input logic [CW-1:0] c, input string nm);
    checks++;
    if (bus.StallCount !== c) begin failures++; $display("FAIL stallcount_%s got=%0d exp=%0d", nm, bus.StallCount, c); end
  endtask
  task automatic exp_busy(input logic b, input string nm);
    checks++;
    if (bus.MDUBusy !== b) begin failures++; $display("FAIL mdubusy_%s got=%b exp=%b", nm, bus.MDUBusy, b); end
  endtask
  task automatic test_reset();
    idle();
    repeat (2) @(posedge clk);
    #1; checks++;
    if ({bus.Stall, bus.exe_RegWrite, bus.exe_RegisterRd, bus.exe_MemRead, bus.mem_RegWrite,
         bus.mem_RegisterRd, bus.mem_MemRead, bus.MDUBusy} !== 15'd0) begin
      failures++; $display("FAIL reset_outputs not all zero");
    end
    exp_cnt(0, "reset");
    @(negedge clk); rst = 0;
  endtask
  task automatic test_load_use_d1();
    set_in(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0); exp_stall(0, "d1_load");
    tick({1'b1, 5'd5, 1'b0} | 7'b1);
    set_in(1, 1, 9, 0, 1, 0, 5, 0, 0, 0, 0);
    exp_stall(1, "d1_c1"); tick(0);
    exp_stall(1, "d1_c2"); tick(0);
    exp_stall(0, "d1_c3"); tick({1'b1, 5'd9, 1'b0});
    idle(); exp_cnt(2, "d1");
  endtask
  task automatic test_load_use_d2();
    set_in(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0); tick({1'b1, 5'd5, 1'b1});
    set_in(1, 1, 3, 0, 1, 0, 4, 0, 0, 0, 0); exp_stall(0, "d2_mid"); tick({1'b1, 5'd3, 1'b0});
    set_in(1, 1, 10, 0, 0, 1, 0, 5, 0, 0, 0); exp_stall(1, "d2_use"); tick(0);
    exp_stall(0, "d2_go"); tick({1'b1, 5'd10, 1'b0});
    exp_cnt(3, "d2_sat");
    set_in(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0); tick({1'b0, 5'd0, 1'b1});
    set_in(1, 1, 11, 0, 1, 0, 0, 0, 0, 0, 0); exp_stall(0, "r0_use"); tick({1'b1, 5'd11, 1'b0});
    idle();
  endtask
  task automatic test_alu();
    set_in(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0); tick({1'b1, 5'd7, 1'b0});
    set_in(1, 1, 8, 0, 1, 0, 7, 0, 0, 0, 0); exp_stall(0, "alu_use"); tick({1'b1, 5'd8, 1'b0});
    idle(); tick(0); tick(0);
  endtask
  task automatic test_mdu();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_stall(0, "mult"); tick(0);
    set_in(1, 1, 12, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin exp_busy(1, "mflo_wait"); exp_stall(1, "mflo_wait"); tick(0); end
    exp_busy(0, "mflo_go"); exp_stall(0, "mflo_go"); tick({1'b1, 5'd12, 1'b0});
    idle(); exp_cnt(3, "mdu_sat");
  endtask
  task automatic test_back_to_back();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_stall(0, "mul1"); tick(0);
    for (int i = 0; i < 4; i++) begin exp_stall(1, "mul2_wait"); tick(0); end
    exp_stall(0, "mul2_go"); tick(0); exp_busy(1, "mul2_reload");
    idle(); repeat (4) tick(0); exp_busy(0, "drained");
  endtask
  task automatic test_flush();
    set_in(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0); tick({1'b1, 5'd5, 1'b1});
    set_in(1, 1, 13, 0, 1, 0, 5, 0, 0, 0, 1); exp_stall(0, "flush"); tick(0);
    idle(); tick(0); tick(0);
  endtask
  task automatic test_reset_mid();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick(0);
    set_in(1, 1, 12, 0, 0, 0, 0, 0, 0, 1, 0); exp_stall(1, "pre_rst"); exp_busy(1, "pre_rst");
    rst = 1; #1;
    exp_busy(0, "in_rst"); exp_stall(0, "in_rst"); exp_cnt(0, "in_rst");
    checks++;
    if ({bus.exe_RegWrite, bus.exe_RegisterRd, bus.exe_MemRead, bus.mem_RegWrite, bus.mem_RegisterRd, bus.mem_MemRead} !== 14'd0) begin
      failures++; $display("FAIL rst_mid_slots not cleared");
    end
    @(negedge clk); rst = 0; prev_exe = '0;
    exp_stall(0, "post_rst"); tick({1'b1, 5'd12, 1'b0});
    exp_cnt(0, "post_rst");
    idle();
  endtask
  initial begin
    test_reset();
    test_load_use_d1();
    test_load_use_d2();
    test_alu();
    test_mdu();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
